// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from hs/vs/draw and tracks line/frame geometry.
// Lock is earned by consecutive well-formed frames and lost on any violation.
module vga_sync_decoder #(
  parameter int H_TOTAL       = 800,
  parameter int H_VISIBLE     = 640,
  parameter int V_TOTAL       = 525,
  parameter int V_VISIBLE     = 480,
  parameter int HS_ACTIVE_LOW = 1,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        draw,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pixel_valid,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [1:0]  state_dbg
);

  localparam logic        HS_IDLE   = (HS_ACTIVE_LOW != 0);
  localparam logic        VS_IDLE   = (VS_ACTIVE_LOW != 0);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  H_VIS_W   = 10'(H_VISIBLE);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0]  V_VIS_W   = 10'(V_VISIBLE);
  localparam logic [2:0]  LOCK_W    = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state;
  logic        hs_q;
  logic        vs_q;
  logic        draw_q;
  logic [10:0] h_cnt;
  logic [9:0]  px_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  act_cnt;
  logic [2:0]  good_cnt;
  logic        line_armed;
  logic        frame_bad;

  logic        hs_edge;
  logic        vs_edge;
  logic        draw_fall;
  logic        line_bad;
  logic        frame_good;

  assign state_dbg = state;

  always_comb begin
    hs_edge    = (hs != HS_IDLE) && (hs_q == HS_IDLE);
    vs_edge    = (vs != VS_IDLE) && (vs_q == VS_IDLE);
    draw_fall  = draw_q && !draw;
    line_bad   = line_armed &&
                 ((hs_edge && (h_cnt != H_TOTAL_W)) ||
                  (draw_fall && (px_cnt != H_VIS_W)));
    // A violation in the same cycle as the vs edge still spoils the frame.
    frame_good = !frame_bad && !line_bad &&
                 (v_cnt == V_TOTAL_W) && (act_cnt == V_VIS_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      hs_q        <= HS_IDLE;
      vs_q        <= VS_IDLE;
      draw_q      <= 1'b0;
      h_cnt       <= '0;
      px_cnt      <= '0;
      v_cnt       <= '0;
      act_cnt     <= '0;
      good_cnt    <= '0;
      line_armed  <= 1'b0;
      frame_bad   <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      hs_q   <= hs;
      vs_q   <= vs;
      draw_q <= draw;

      if (hs_edge) begin
        h_cnt    <= 11'd1;
        line_len <= h_cnt;
      end else if (h_cnt != 11'h7ff) begin
        h_cnt <= h_cnt + 11'd1;
      end

      if (hs_edge) begin
        px_cnt <= '0;
      end else if (draw && (px_cnt != 10'h3ff)) begin
        px_cnt <= px_cnt + 10'd1;
      end

      // A coincident hs edge is the first line of the new frame.
      if (vs_edge) begin
        frame_lines <= v_cnt;
        v_cnt       <= hs_edge ? 10'd1 : 10'd0;
      end else if (hs_edge && (v_cnt != 10'h3ff)) begin
        v_cnt <= v_cnt + 10'd1;
      end

      if (vs_edge) begin
        act_cnt <= '0;
      end else if (draw_fall && (act_cnt != 10'h3ff)) begin
        act_cnt <= act_cnt + 10'd1;
      end

      pixel_valid <= draw;
      if (draw) begin
        x <= px_cnt;
        y <= act_cnt;
      end

      frame_start <= vs_edge;
      sync_err    <= 1'b0;

      if (state == SEARCH) begin
        line_armed <= 1'b0;
      end else if (hs_edge) begin
        line_armed <= 1'b1;
      end

      if (vs_edge) begin
        frame_bad <= 1'b0;
      end else if (line_bad) begin
        frame_bad <= 1'b1;
      end

      case (state)
        SEARCH: begin
          locked   <= 1'b0;
          good_cnt <= '0;
          if (vs_edge) begin
            state <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (vs_edge) begin
            if (frame_good) begin
              good_cnt <= good_cnt + 3'd1;
              if ((good_cnt + 3'd1) == LOCK_W) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (line_bad) begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (line_bad || (vs_edge && !frame_good)) begin
            sync_err <= 1'b1;
            locked   <= 1'b0;
            good_cnt <= '0;
            state    <= ACQUIRE;
          end
        end
        default: begin
          state    <= SEARCH;
          locked   <= 1'b0;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: active-low and active-high instances share one
// stream; expectations come from the stream layout and a frame-level lock model.
module tb_vga_sync_decoder;

  localparam int HT     = 20;
  localparam int HV     = 16;
  localparam int VT     = 12;
  localparam int VV     = 8;
  localparam int HS_COL = 17;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic hs    = 1'b1;
  logic vs    = 1'b1;
  logic draw  = 1'b0;
  logic hs_p;
  logic vs_p;

  logic [9:0]  x_o  [2];
  logic [9:0]  y_o  [2];
  logic        pv_o [2];
  logic [10:0] ll_o [2];
  logic [9:0]  fl_o [2];
  logic        lk_o [2];
  logic        fs_o [2];
  logic        se_o [2];
  logic [1:0]  st_o [2];

  assign hs_p = ~hs;
  assign vs_p = ~vs;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_VISIBLE(HV), .V_TOTAL(VT), .V_VISIBLE(VV),
    .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .hs(hs), .vs(vs), .draw(draw),
    .x(x_o[0]), .y(y_o[0]), .pixel_valid(pv_o[0]), .line_len(ll_o[0]),
    .frame_lines(fl_o[0]), .locked(lk_o[0]), .frame_start(fs_o[0]),
    .sync_err(se_o[0]), .state_dbg(st_o[0])
  );

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_VISIBLE(HV), .V_TOTAL(VT), .V_VISIBLE(VV),
    .HS_ACTIVE_LOW(0), .VS_ACTIVE_LOW(0), .LOCK_FRAMES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .hs(hs_p), .vs(vs_p), .draw(draw),
    .x(x_o[1]), .y(y_o[1]), .pixel_valid(pv_o[1]), .line_len(ll_o[1]),
    .frame_lines(fl_o[1]), .locked(lk_o[1]), .frame_start(fs_o[1]),
    .sync_err(se_o[1]), .state_dbg(st_o[1])
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // scoreboard: expected {y, x} of each visible pixel driven
  logic [19:0] exp_q[$];

  // frame-level reference model
  bit m_search    = 1'b1;
  bit m_locked    = 1'b0;
  int m_good      = 0;
  bit m_frame_bad = 1'b0;
  bit m_armed     = 1'b0;
  int prev_n      = VT;
  bit len_ok      = 1'b0;
  bit x_ok        = 1'b1;
  bit y_ok        = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_x[%0d]", i), x_o[i], 0);
      check($sformatf("rst_y[%0d]", i), y_o[i], 0);
      check($sformatf("rst_pixel_valid[%0d]", i), pv_o[i], 0);
      check($sformatf("rst_line_len[%0d]", i), ll_o[i], 0);
      check($sformatf("rst_frame_lines[%0d]", i), fl_o[i], 0);
      check($sformatf("rst_locked[%0d]", i), lk_o[i], 0);
      check($sformatf("rst_frame_start[%0d]", i), fs_o[i], 0);
      check($sformatf("rst_sync_err[%0d]", i), se_o[i], 0);
      check($sformatf("rst_state[%0d]", i), st_o[i], 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_zero();
    m_search    = 1'b1;
    m_locked    = 1'b0;
    m_good      = 0;
    m_frame_bad = 1'b0;
    m_armed     = 1'b0;
    len_ok      = 1'b0;
    x_ok        = 1'b0;
    y_ok        = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // driver: one frame of n_lines; optional stretched line, vs column, reset point
  task automatic run_frame(input int n_lines, input int stretch, input int vs_col, input int rst_line);
    int pv_cnt [2];
    pv_cnt[0] = 0;
    pv_cnt[1] = 0;
    for (int l = 0; l < n_lines; l++) begin
      int len;
      len = (l == stretch) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        bit hs_on, vs_on, dr, hs_e, vs_e, judged, exp_err, exp_fs;
        int exp_len;
        logic [19:0] px;
        hs_on  = (c >= HS_COL) && (c < HS_COL + 2);
        vs_on  = ((l == VV + 1) && (c >= vs_col)) || (l == VV + 2);
        dr     = (l < VV) && (c < HV);
        hs_e   = (c == HS_COL);
        vs_e   = (l == VV + 1) && (c == vs_col);
        hs     = ~hs_on;
        vs     = ~vs_on;
        draw   = dr;
        px     = '0;
        if (dr) exp_q.push_back({10'(l), 10'(c)});
        exp_len = ((l > 0) && (l - 1 == stretch)) ? HT + 1 : HT;

        exp_err = 1'b0;
        exp_fs  = vs_e;
        judged  = 1'b0;
        if (hs_e && m_armed && (exp_len != HT)) begin
          m_good      = 0;
          m_frame_bad = 1'b1;
          if (m_locked) begin
            exp_err  = 1'b1;
            m_locked = 1'b0;
          end
        end
        if (hs_e && !m_search) m_armed = 1'b1;
        if (vs_e) begin
          if (m_search) begin
            m_search = 1'b0;
          end else begin
            judged = 1'b1;
            if (!m_frame_bad && (prev_n == VT)) begin
              if (!m_locked) begin
                m_good++;
                if (m_good >= 2) m_locked = 1'b1;
              end
            end else begin
              if (m_locked) exp_err = 1'b1;
              m_locked = 1'b0;
              m_good   = 0;
            end
          end
          m_frame_bad = 1'b0;
        end

        @(posedge clk);
        #1;
        if (dr) px = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          check($sformatf("pixel_valid[%0d]", i), pv_o[i], dr);
          if (dr && x_ok) check($sformatf("x[%0d]", i), x_o[i], px[9:0]);
          if (dr && y_ok) check($sformatf("y[%0d]", i), y_o[i], px[19:10]);
          check($sformatf("frame_start[%0d]", i), fs_o[i], exp_fs);
          check($sformatf("sync_err[%0d]", i), se_o[i], exp_err);
          check($sformatf("locked[%0d]", i), lk_o[i], m_locked);
          if (hs_e && len_ok) check($sformatf("line_len[%0d]", i), ll_o[i], exp_len);
          if (judged) check($sformatf("frame_lines[%0d]", i), fl_o[i], prev_n);
          if (pv_o[i]) pv_cnt[i]++;
        end
        if (hs_e) begin
          len_ok = 1'b1;
          x_ok   = 1'b1;
        end
        if (vs_e) y_ok = 1'b1;
        if ((l == rst_line) && (c == 5)) do_reset();
      end
    end
    prev_n = n_lines;
    if (rst_line < 0) begin
      for (int i = 0; i < 2; i++) check($sformatf("pixels_per_frame[%0d]", i), pv_cnt[i], HV * VV);
    end
  endtask

  initial begin
    #12;
    check_zero();
    @(negedge clk);
    reset = 1'b1;

    // ideal stream from reset: lock one cycle after the 3rd vs edge
    repeat (4) run_frame(VT, -1, 0, -1);
    for (int i = 0; i < 2; i++) check($sformatf("locked_ideal[%0d]", i), lk_o[i], 1);

    // one 21-clock line while locked
    run_frame(VT, 3, 0, -1);
    repeat (3) run_frame(VT, -1, 0, -1);

    // one 13-line frame while locked
    run_frame(VT + 1, -1, 0, -1);
    repeat (3) run_frame(VT, -1, 0, -1);

    // vs edge coincident with hs edge
    repeat (3) run_frame(VT, -1, HS_COL, -1);

    // reset mid-line while locked
    run_frame(VT, -1, 0, 3);
    repeat (4) run_frame(VT, -1, 0, -1);

    // randomized mix of good and faulty frames
    for (int f = 0; f < 24; f++) begin
      int kind, col;
      kind = $urandom_range(0, 5);
      col  = ($urandom_range(0, 1) == 1) ? HS_COL : 0;
      case (kind)
        3:       run_frame(VT, $urandom_range(0, 7), col, -1);
        4:       run_frame(VT + 1, -1, col, -1);
        5:       run_frame(VT - 1, -1, col, -1);
        default: run_frame(VT, -1, col, -1);
      endcase
    end
    repeat (3) run_frame(VT, -1, 0, -1);
    for (int i = 0; i < 2; i++) check($sformatf("locked_final[%0d]", i), lk_o[i], 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
